// File: rtl/serial_feeder_pkg.sv
// Shared types and defaults for the serial word feeder.
// Holds the FSM state encoding and parameter defaults.
package serial_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    PARITY = 2'b10
  } state_t;

  localparam int   DEF_WIDTH    = 8;
  localparam logic DEF_IDLE_BIT = 1'b0;

endpackage

// File: rtl/ser_bit_counter.sv
// Loadable down-counter with zero flag.
// Shared by serial stages that count bits per word.
module ser_bit_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] cnt;

  // Load has priority over decrement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial word feeder, MSB first, valid/ready input.
// Define SER_PARITY_EN to append an even-parity bit per word.
module serial_word_feeder
  import serial_feeder_pkg::*;
#(
  parameter int   WIDTH    = DEF_WIDTH,
  parameter logic IDLE_BIT = DEF_IDLE_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sreg;
  logic             zero;
  logic             rdy;
  logic             xfer;
  logic             ser_q;
  logic             vld_q;
  logic             busy_q;
`ifdef SER_PARITY_EN
  logic             par_q;
`endif

  assign xfer = in_valid && in_ready;

  ser_bit_counter #(
    .CW(CW)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (xfer),
    .en      (state == SHIFT && !zero),
    .load_val(LAST),
    .zero    (zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (xfer) state_nx = SHIFT;
      end
      SHIFT: begin
        if (zero) begin
`ifdef SER_PARITY_EN
          state_nx = PARITY;
`else
          state_nx = xfer ? SHIFT : IDLE;
`endif
        end
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        state_nx = xfer ? SHIFT : IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Ready decode, held low during reset.
  always_comb begin
    rdy = 1'b0;
    case (state)
      IDLE: rdy = 1'b1;
`ifdef SER_PARITY_EN
      PARITY: rdy = 1'b1;
`else
      SHIFT: rdy = zero;
`endif
      default: rdy = 1'b0;
    endcase
    in_ready = rst && rdy;
  end

  // Shift datapath and registered serial outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg   <= '0;
      ser_q  <= IDLE_BIT;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
`ifdef SER_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      vld_q  <= (state_nx != IDLE);
      busy_q <= (state_nx != IDLE);
      if (xfer) begin
        sreg  <= in_data;
        ser_q <= in_data[WIDTH-1];
`ifdef SER_PARITY_EN
        par_q <= 1'b0;
`endif
      end else if (state == SHIFT) begin
        sreg <= sreg << 1;
`ifdef SER_PARITY_EN
        par_q <= par_q ^ sreg[WIDTH-1];
`endif
        if (zero) begin
`ifdef SER_PARITY_EN
          ser_q <= par_q ^ sreg[WIDTH-1];
`else
          ser_q <= IDLE_BIT;
`endif
        end else begin
          ser_q <= sreg[WIDTH-2];
        end
      end else begin
        ser_q <= IDLE_BIT;
      end
    end
  end

  assign ser_bit   = ser_q;
  assign ser_valid = vld_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Self-checking bench for serial_word_feeder.
// Reference model: a queue of bits still to be emitted.
module tb_serial_word_feeder;

  localparam int   W  = 8;
  localparam logic IB = 1'b0;
`ifdef SER_PARITY_EN
  localparam int WL = W + 1;
`else
  localparam int WL = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         ser_bit;
  logic         ser_valid;
  logic         busy;

  int checks = 0;
  int errors = 0;

  bit q[$];
  int acc_cnt = 0;
  logic m_xf;

  serial_word_feeder #(
    .WIDTH   (W),
    .IDLE_BIT(IB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .ser_bit  (ser_bit),
    .ser_valid(ser_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Model: ready when at most the current bit remains; a word appends
  // its bits MSB first (plus even parity) behind the current bit.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
    end else begin
      m_xf = in_valid && (q.size() <= 1);
      if (q.size() > 0) void'(q.pop_front());
      if (m_xf) begin
        for (int i = W - 1; i >= 0; i--) q.push_back(in_data[i]);
`ifdef SER_PARITY_EN
        q.push_back(^in_data);
`endif
        acc_cnt++;
      end
    end
  end

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_ready got %b want 0", in_ready);
    end
    checks++;
    if (ser_valid !== 1'b0 || busy !== 1'b0 || ser_bit !== IB) begin
      errors++;
      $display("FAIL rst_outs got v=%b b=%b s=%b want 0 0 %b",
               ser_valid, busy, ser_bit, IB);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || ser_valid !== 1'b0 || busy !== 1'b0 ||
        ser_bit !== IB) begin
      errors++;
      $display("FAIL idle got r=%b v=%b b=%b s=%b want 1 0 0 %b",
               in_ready, ser_valid, busy, ser_bit, IB);
    end
  endtask

  task automatic test_single_word();
    bit s[$];
    int hits = 0;
    logic [W-1:0] got = '0;
    in_valid = 1'b1;
    in_data  = 8'hA0;
    for (int c = 0; c < WL + 3; c++) begin
      @(negedge clk);
      checks++;
      if (ser_valid !== (q.size() > 0) ||
          busy !== (q.size() > 0)) begin
        errors++;
        $display("FAIL single_valid c=%0d got v=%b b=%b want %b",
                 c, ser_valid, busy, q.size() > 0);
      end
      if (q.size() > 0) begin
        checks++;
        if (ser_bit !== q[0]) begin
          errors++;
          $display("FAIL single_bit c=%0d got %b want %b", c, ser_bit, q[0]);
        end
      end
      if (ser_valid) s.push_back(ser_bit);
      in_valid = 1'b0;
    end
    for (int i = 0; i < W && i < s.size(); i++) got[W-1-i] = s[i];
    checks++;
    if (s.size() != WL || got !== 8'hA0) begin
      errors++;
      $display("FAIL single_word got %h len %0d want a0 len %0d",
               got, s.size(), WL);
    end
    for (int i = 2; i < s.size(); i++)
      if (s[i-2] && !s[i-1] && s[i]) hits++;
    checks++;
    if (hits != 1) begin
      errors++; $display("FAIL detect101 got %0d want 1", hits);
    end
  endtask

  task automatic test_back_to_back();
    bit s[$];
    int run = 0;
    int best = 0;
    int base = acc_cnt;
    logic [2*WL-1:0] exp_s;
    logic [2*WL-1:0] got_s = '0;
`ifdef SER_PARITY_EN
    exp_s = {8'hF0, 1'b0, 8'h0F, 1'b0};
`else
    exp_s = {8'hF0, 8'h0F};
`endif
    in_valid = 1'b1;
    in_data  = 8'hF0;
    for (int c = 0; c < 2 * WL + 4; c++) begin
      @(negedge clk);
      checks++;
      if (ser_valid !== (q.size() > 0) ||
          (q.size() > 0 && ser_bit !== q[0])) begin
        errors++;
        $display("FAIL b2b_cycle c=%0d got v=%b s=%b want v=%b",
                 c, ser_valid, ser_bit, q.size() > 0);
      end
      checks++;
      if (in_ready !== (q.size() <= 1)) begin
        errors++;
        $display("FAIL b2b_ready c=%0d got %b want %b",
                 c, in_ready, q.size() <= 1);
      end
      if (ser_valid) begin
        s.push_back(ser_bit);
        run++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
      if (acc_cnt - base == 1) in_data = 8'h0F;
      if (acc_cnt - base >= 2) in_valid = 1'b0;
    end
    checks++;
    if (best != 2 * WL || acc_cnt - base != 2) begin
      errors++;
      $display("FAIL b2b_run got %0d xfers %0d want %0d xfers 2",
               best, acc_cnt - base, 2 * WL);
    end
    for (int i = 0; i < 2 * WL && i < s.size(); i++)
      got_s[2*WL-1-i] = s[i];
    checks++;
    if (got_s !== exp_s) begin
      errors++; $display("FAIL b2b_stream got %h want %h", got_s, exp_s);
    end
  endtask

  task automatic test_held_valid();
    int dut_xf = 0;
    int want;
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int c = 0; c < 41; c++) begin
      if (in_valid && in_ready) dut_xf++;
      @(negedge clk);
      checks++;
      if (ser_valid !== (q.size() > 0) || in_ready !== (q.size() <= 1) ||
          (q.size() > 0 && ser_bit !== q[0])) begin
        errors++;
        $display("FAIL held_cycle c=%0d got v=%b r=%b s=%b",
                 c, ser_valid, in_ready, ser_bit);
      end
    end
    in_valid = 1'b0;
    want = (40 / WL) + 1;
    checks++;
    if (dut_xf != want) begin
      errors++; $display("FAIL held_xfers got %0d want %0d", dut_xf, want);
    end
    for (int c = 0; c < WL + 2; c++) @(negedge clk);
  endtask

  task automatic test_reset_mid_word();
    in_valid = 1'b1;
    in_data  = 8'hA5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (ser_valid !== 1'b1 || ser_bit !== q[0]) begin
        errors++;
        $display("FAIL mid_bits c=%0d got v=%b s=%b want 1 %b",
                 c, ser_valid, ser_bit, q[0]);
      end
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ser_valid !== 1'b0 || ser_bit !== IB || busy !== 1'b0 ||
        in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_abort got v=%b s=%b b=%b r=%b want 0 %b 0 0",
               ser_valid, ser_bit, busy, in_ready, IB);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < WL + 2; c++) begin
      @(negedge clk);
      checks++;
      if (ser_valid !== 1'b0 || in_ready !== 1'b1 || ser_bit !== IB) begin
        errors++;
        $display("FAIL mid_residue c=%0d got v=%b r=%b s=%b",
                 c, ser_valid, in_ready, ser_bit);
      end
    end
  endtask

`ifdef SER_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] w [2];
    logic         p [2];
    w[0] = 8'hA5; p[0] = 1'b0;
    w[1] = 8'h07; p[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      int rdy_hi = 0;
      in_valid = 1'b1;
      in_data  = w[k];
      for (int c = 1; c <= WL; c++) begin
        @(negedge clk);
        in_valid = 1'b0;
        if (in_ready) rdy_hi++;
        if (c == WL) begin
          checks++;
          if (ser_valid !== 1'b1 || ser_bit !== p[k] || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL parity_bit w=%h got v=%b s=%b r=%b want 1 %b 1",
                     w[k], ser_valid, ser_bit, in_ready, p[k]);
          end
        end
      end
      checks++;
      if (rdy_hi != 1) begin
        errors++; $display("FAIL parity_ready got %0d want 1", rdy_hi);
      end
      @(negedge clk);
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++;
      if (ser_valid !== (q.size() > 0) || busy !== (q.size() > 0) ||
          in_ready !== (q.size() <= 1) ||
          ser_bit !== ((q.size() > 0) ? q[0] : IB)) begin
        errors++;
        $display("FAIL rand c=%0d got v=%b b=%b r=%b s=%b qsz=%0d",
                 c, ser_valid, busy, in_ready, ser_bit, q.size());
      end
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = W'($urandom);
    end
    in_valid = 1'b0;
    for (int c = 0; c < WL + 2; c++) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_held_valid();
    test_reset_mid_word();
`ifdef SER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
